conv_layer_seq: RTL

Sequencer for one binarised convolution layer of the same parameterisation. It loads weights and thresholds from a host beat interface, then streams one input feature map through the layer. While streaming it sweeps `fold_add` across all output-channel folds for every pixel, pulses the max-pool enable, and flags valid output pixels. It sits between the layer-level host/DMA logic and the conv datapath, and drives all datapath control ports. Data buses go to the datapath directly and never pass through this block.

---
 rtl/conv_layer_seq.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_seq.sv
// ---------------------------------------------------------------------------
// conv_layer_seq
//
// Control sequencer for one binarised convolution layer. A run loads the
// weights and then the thresholds from the host beat interface. It then
// streams one input feature map through the conv datapath, followed by
// enough zero "flush" beats to push the last valid window through.
//
// For every accepted beat, the sequencer sweeps fold_add across all
// output-channel folds. It also marks which beats produce a valid conv
// result and, in pool mode, which of those results complete a max-pool
// window. Data buses never pass through this block.
//
// Ports
//    clk, reset           clock, asynchronous active-low reset
//    start                begin a run (only looked at while idle)
//    ld_valid / ld_ready  host load beat handshake (weights, then thresholds)
//    act_valid/act_ready  activation pixel handshake
//    act_flush            zero-mux select for the activation bus on flush beats
//    stream_w_en          weight write/shift enable (ld_valid & ld_ready)
//    stream_w_addr        weight memory address (beat count)
//    stream_th_en         threshold shift enable (ld_valid & ld_ready)
//    stream_act_en        activation buffer shift enable (pixel or flush beat)
//    fold_add             fold currently being evaluated
//    stream_maxpool_en    max-pool sample enable, one per valid conv result
//    out_valid            datapath output holds a valid pixel this cycle
//    busy                 run in progress
//    done                 one-cycle pulse when the run has fully drained
// ---------------------------------------------------------------------------
module conv_layer_seq #(
   parameter int fold           = 1,
   parameter int fold_log       = (fold > 1) ? $clog2(fold) : 1,
   parameter int ch_out         = 64,
   parameter int w_in           = 32,
   parameter int k_s            = 3,
   parameter int pad            = 1,
   parameter int MAXPOOL_enable = 1,
   parameter int k_s_maxpool    = 2,
   parameter int warmup         = w_in*(k_s-1-pad)+(k_s-1-pad),
   parameter int mp_lat         = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic                act_valid,
   output logic                act_ready,
   output logic                act_flush,
   output logic                stream_w_en,
   output logic [fold_log-1:0] stream_w_addr,
   output logic                stream_th_en,
   output logic                stream_act_en,
   output logic [fold_log-1:0] fold_add,
   output logic                stream_maxpool_en,
   output logic                out_valid,
   output logic                busy,
   output logic                done
);

   // With a single fold the weights arrive through a shift chain, one beat
   // per output channel; otherwise there is one wide beat per fold.
   localparam int LD_W_BEATS = (fold == 1) ? ch_out : fold;
   localparam int CNT_W      = $clog2(ch_out + fold + 1) + 1;
   localparam int PIX_W      = $clog2(w_in) + 1;
   localparam int WU_W       = $clog2(warmup + 2) + 1;
   localparam int DR_W       = $clog2(fold + mp_lat + 4) + 1;
   localparam int PIPE_LEN   = fold + 2 + mp_lat;

   localparam logic [CNT_W-1:0]    W_LAST     = CNT_W'(LD_W_BEATS - 1);
   localparam logic [CNT_W-1:0]    TH_LAST    = CNT_W'(ch_out - 1);
   localparam logic [PIX_W-1:0]    PIX_LAST   = PIX_W'(w_in - 1);
   localparam logic [PIX_W-1:0]    POOL_LAST  = PIX_W'(k_s_maxpool - 1);
   localparam logic [fold_log-1:0] FOLD_LAST  = fold_log'(fold - 1);
   localparam logic [WU_W-1:0]     WU_FULL    = WU_W'(warmup);
   localparam logic [WU_W-1:0]     FLUSH_LAST = WU_W'(warmup - 1);
   localparam logic [DR_W-1:0]     DRAIN_LAST = DR_W'(fold + 1 + mp_lat);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_TH,
      S_RUN,
      S_FLUSH,
      S_DRAIN
   } state_t;

   state_t              state_q,     state_d;
   logic [CNT_W-1:0]    ld_cnt_q,    ld_cnt_d;
   logic [PIX_W-1:0]    pix_row_q,   pix_row_d;
   logic [PIX_W-1:0]    pix_col_q,   pix_col_d;
   logic [WU_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [WU_W-1:0]     wu_cnt_q,    wu_cnt_d;
   logic [PIX_W-1:0]    o_col_q,     o_col_d;
   logic [PIX_W-1:0]    pc_q,        pc_d;
   logic [PIX_W-1:0]    pr_q,        pr_d;
   logic                sweep_q,     sweep_d;
   logic [fold_log-1:0] fold_add_q,  fold_add_d;
   logic [DR_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic                ld_ready_q,  ld_ready_d;
   logic                act_ready_q, act_ready_d;
   logic                act_flush_q, act_flush_d;
   logic [fold_log-1:0] w_addr_q,    w_addr_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   // Each entry carries {completes a pool window, valid conv result} for
   // one beat, delayed so that it lines up with the datapath latency.
   logic [1:0]          pipe_q [PIPE_LEN];
   logic [1:0]          pipe_d [PIPE_LEN];

   logic w_beat, th_beat, pix_beat, flush_beat, beat;
   logic last_pix, conv_valid, pool_hit, slot_d;

   // Handshake terminations are deliberately combinational; everything
   // else leaving the block comes straight from a flop.
   assign w_beat     = (state_q == S_LOAD_W)  & ld_valid & ld_ready_q;
   assign th_beat    = (state_q == S_LOAD_TH) & ld_valid & ld_ready_q;
   assign pix_beat   = (state_q == S_RUN)     & act_valid & act_ready_q;
   assign flush_beat = (state_q == S_FLUSH)   & act_flush_q;
   assign beat       = pix_beat | flush_beat;

   assign last_pix   = (pix_row_q == PIX_LAST) && (pix_col_q == PIX_LAST);
   // Beats before the warmup count only fill the line buffers.
   assign conv_valid = (wu_cnt_q == WU_FULL);
   assign pool_hit   = conv_valid && (pc_q == POOL_LAST) && (pr_q == POOL_LAST);

   // Next-state, counters and registered output decode.
   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      pix_row_d   = pix_row_q;
      pix_col_d   = pix_col_q;
      flush_cnt_d = flush_cnt_q;
      wu_cnt_d    = wu_cnt_q;
      o_col_d     = o_col_q;
      pc_d        = pc_q;
      pr_d        = pr_q;
      sweep_d     = sweep_q;
      fold_add_d  = fold_add_q;
      drain_cnt_d = drain_cnt_q;
      done_d      = 1'b0;

      // A new beat always restarts the fold sweep from fold 0; a beat on the
      // final sweep cycle gives back-to-back operation.
      if (beat) begin
         sweep_d    = 1'b1;
         fold_add_d = '0;
      end else if (sweep_q) begin
         if (fold_add_q == FOLD_LAST) begin
            sweep_d    = 1'b0;
            fold_add_d = '0;
         end else begin
            fold_add_d = fold_add_q + fold_log'(1);
         end
      end

      // Output coordinate tracking, kept modulo the pool window so no
      // divider is needed.
      if (beat) begin
         if (!conv_valid) begin
            wu_cnt_d = wu_cnt_q + WU_W'(1);
         end else if (o_col_q == PIX_LAST) begin
            o_col_d = '0;
            pc_d    = '0;
            pr_d    = (pr_q == POOL_LAST) ? '0 : pr_q + PIX_W'(1);
         end else begin
            o_col_d = o_col_q + PIX_W'(1);
            pc_d    = (pc_q == POOL_LAST) ? '0 : pc_q + PIX_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD_W;
               ld_cnt_d    = '0;
               pix_row_d   = '0;
               pix_col_d   = '0;
               flush_cnt_d = '0;
               wu_cnt_d    = '0;
               o_col_d     = '0;
               pc_d        = '0;
               pr_d        = '0;
               drain_cnt_d = '0;
            end
         end
         S_LOAD_W: begin
            if (w_beat) begin
               if (ld_cnt_q == W_LAST) begin
                  state_d  = S_LOAD_TH;
                  ld_cnt_d = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + CNT_W'(1);
               end
            end
         end
         S_LOAD_TH: begin
            if (th_beat) begin
               if (ld_cnt_q == TH_LAST) begin
                  state_d  = S_RUN;
                  ld_cnt_d = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + CNT_W'(1);
               end
            end
         end
         S_RUN: begin
            if (pix_beat) begin
               if (pix_col_q == PIX_LAST) begin
                  pix_col_d = '0;
                  pix_row_d = pix_row_q + PIX_W'(1);
               end else begin
                  pix_col_d = pix_col_q + PIX_W'(1);
               end
               if (last_pix) begin
                  state_d = (warmup == 0) ? S_DRAIN : S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (flush_beat) begin
               if (flush_cnt_q == FLUSH_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  flush_cnt_d = flush_cnt_q + WU_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // Held until the last beat has left the pool stage.
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + DR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A beat slot opens when no sweep runs or the sweep is on its last fold.
      slot_d      = !sweep_d || (fold_add_d == FOLD_LAST);
      ld_ready_d  = (state_d == S_LOAD_W) || (state_d == S_LOAD_TH);
      act_ready_d = (state_d == S_RUN) && slot_d;
      act_flush_d = (state_d == S_FLUSH) && slot_d;
      w_addr_d    = (state_d == S_LOAD_W) ? ld_cnt_d[fold_log-1:0] : '0;
      busy_d      = (state_d != S_IDLE);

      pipe_d[0] = {beat & pool_hit, beat & conv_valid};
      for (int i = 1; i < PIPE_LEN; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // State and output registers; reset abandons any partial load or run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ld_cnt_q    <= '0;
         pix_row_q   <= '0;
         pix_col_q   <= '0;
         flush_cnt_q <= '0;
         wu_cnt_q    <= '0;
         o_col_q     <= '0;
         pc_q        <= '0;
         pr_q        <= '0;
         sweep_q     <= 1'b0;
         fold_add_q  <= '0;
         drain_cnt_q <= '0;
         ld_ready_q  <= 1'b0;
         act_ready_q <= 1'b0;
         act_flush_q <= 1'b0;
         w_addr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < PIPE_LEN; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         pix_row_q   <= pix_row_d;
         pix_col_q   <= pix_col_d;
         flush_cnt_q <= flush_cnt_d;
         wu_cnt_q    <= wu_cnt_d;
         o_col_q     <= o_col_d;
         pc_q        <= pc_d;
         pr_q        <= pr_d;
         sweep_q     <= sweep_d;
         fold_add_q  <= fold_add_d;
         drain_cnt_q <= drain_cnt_d;
         ld_ready_q  <= ld_ready_d;
         act_ready_q <= act_ready_d;
         act_flush_q <= act_flush_d;
         w_addr_q    <= w_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pipe_q      <= pipe_d;
      end
   end

   assign ld_ready      = ld_ready_q;
   assign act_ready     = act_ready_q;
   assign act_flush     = act_flush_q;
   assign stream_w_en   = w_beat;
   assign stream_th_en  = th_beat;
   assign stream_act_en = beat;
   assign stream_w_addr = w_addr_q;
   assign fold_add      = fold_add_q;
   assign busy          = busy_q;
   assign done          = done_q;

   // A conv result reaches the pool sampler fold+1 cycles after its beat.
   // A completed pool window appears 1+mp_lat cycles after that.
   assign stream_maxpool_en = (MAXPOOL_enable != 0) ? pipe_q[fold][0] : 1'b0;
   assign out_valid         = (MAXPOOL_enable != 0) ? pipe_q[PIPE_LEN-1][1]
                                                    : pipe_q[fold][0];

endmodule
